// File: rtl/yu_core_pkg.sv
// Shared definitions for the Yu core front end: next-PC select encodings,
// PC generator state type and alignment helper.
package yu_core_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;
    localparam logic [1:0] PC_SRC_TRAP   = 2'd3;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    // Number of low address bits that must be zero for a given alignment.
    function automatic int align_bits(input int ialign);
        return (ialign == 2) ? 1 : 2;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-side bundle between decode/branch logic, the PC generator and the
// instruction memory port.  master = PC generator, slave = its environment.
interface pc_gen_if
    import yu_core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) ();

    logic [1:0]      pc_src;
    logic            redirect;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] trap_vec;
    logic            fetch_ready;
    logic            fetch_valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_link;
    logic            misaligned;
    logic [XLEN-1:0] bad_addr;

    modport master (
        input  pc_src, redirect, imm, rs1, trap_vec, fetch_ready,
        output fetch_valid, pc, pc_link, misaligned, bad_addr
    );

    modport slave (
        output pc_src, redirect, imm, rs1, trap_vec, fetch_ready,
        input  fetch_valid, pc, pc_link, misaligned, bad_addr
    );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational next-PC target selection and alignment check.
// Trap vectors are forced aligned, so only BRANCH and JALR can flag an error.
module pc_target_calc
    import yu_core_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int IALIGN = 4
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] trap_vec,
    input  logic [1:0]      pc_src,
    output logic [XLEN-1:0] target,
    output logic            align_err
);

    localparam int              ALIGN_BITS = align_bits(IALIGN);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'((1 << ALIGN_BITS) - 1);
    localparam logic [XLEN-1:0] JALR_MASK  = ~XLEN'(1);

    // Select target; JALR bit-0 clear happens before the alignment test.
    always_comb begin
        target    = pc + XLEN'(4);
        align_err = 1'b0;
        case (pc_src)
            PC_SRC_SEQ:    target = pc + XLEN'(4);
            PC_SRC_BRANCH: target = pc + imm;
            PC_SRC_JALR:   target = (rs1 + imm) & JALR_MASK;
            PC_SRC_TRAP:   target = trap_vec & ALIGN_MASK;
            default:       target = pc + XLEN'(4);
        endcase
        if (pc_src == PC_SRC_BRANCH || pc_src == PC_SRC_JALR) begin
            align_err = |target[ALIGN_BITS-1:0];
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: holds the reset vector for one fetch, steps by 4
// on accepted fetches, applies BRANCH/JALR/TRAP redirects and halts on a
// misaligned target until a trap redirect arrives.
//
// state | meaning
// BOOT  | in/just out of reset, no fetch request, pc = reset vector
// RUN   | fetch_valid high, pc advances on accept or redirect
// HALT  | misaligned target seen, only a TRAP redirect restarts fetch
module pc_gen
    import yu_core_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              IALIGN       = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);

    pc_state_t       state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] bad_addr_q;
    logic            fetch_valid_q;
    logic            misaligned_q;
    logic [XLEN-1:0] target;
    logic            align_err;
    logic            redirect_en;
    logic            trap_req;
    logic            accept;

    assign redirect_en = bus.redirect && (bus.pc_src != PC_SRC_SEQ);
    assign trap_req    = bus.redirect && (bus.pc_src == PC_SRC_TRAP);
    assign accept      = fetch_valid_q && bus.fetch_ready;

    pc_target_calc #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_target_calc (
        .pc        (pc_q),
        .imm       (bus.imm),
        .rs1       (bus.rs1),
        .trap_vec  (bus.trap_vec),
        .pc_src    (bus.pc_src),
        .target    (target),
        .align_err (align_err)
    );

    // Sequencing FSM with registered pc, fetch_valid, misaligned and bad_addr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= BOOT;
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            bad_addr_q    <= '0;
        end else begin
            misaligned_q <= 1'b0;
            case (state)
                BOOT: begin
                    state         <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    if (redirect_en) begin
                        if (align_err) begin
                            state         <= HALT;
                            fetch_valid_q <= 1'b0;
                            misaligned_q  <= 1'b1;
                            bad_addr_q    <= target;
                        end else begin
                            pc_q <= target;
                        end
                    end else if (accept) begin
                        pc_q <= pc_q + XLEN'(4);
                    end
                end
                HALT: begin
                    if (trap_req) begin
                        state         <= RUN;
                        fetch_valid_q <= 1'b1;
                        pc_q          <= target;
                    end
                end
                default: begin
                    state         <= BOOT;
                    fetch_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_link     = pc_q + XLEN'(4);
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.misaligned  = misaligned_q;
    assign bus.bad_addr    = bad_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (IALIGN=4 and IALIGN=2, reset vector 0x100)
// driven by the same stimulus and compared against a behavioural model.
module tb_pc_gen;
    import yu_core_pkg::*;

    localparam logic [31:0] RV = 32'h100;

    logic        clk;
    logic        rst;
    logic [1:0]  pc_src;
    logic        redirect;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] trap_vec;
    logic        fetch_ready;

    int n_chk  = 0;
    int n_fail = 0;

    // model: mode 0 = waiting first fetch, 1 = fetching, 2 = halted
    int          m_mode [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_bad  [2];
    logic        m_mis  [2];

    pc_gen_if #(.XLEN(32)) if4 ();
    pc_gen_if #(.XLEN(32)) if2 ();

    assign if4.pc_src      = pc_src;
    assign if4.redirect    = redirect;
    assign if4.imm         = imm;
    assign if4.rs1         = rs1;
    assign if4.trap_vec    = trap_vec;
    assign if4.fetch_ready = fetch_ready;
    assign if2.pc_src      = pc_src;
    assign if2.redirect    = redirect;
    assign if2.imm         = imm;
    assign if2.rs1         = rs1;
    assign if2.trap_vec    = trap_vec;
    assign if2.fetch_ready = fetch_ready;

    pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4)
    );

    pc_gen #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = 0;
            m_pc[k]   = RV;
            m_bad[k]  = 32'h0;
            m_mis[k]  = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int unsigned ia;
            logic [31:0] tgt;
            ia = (k == 0) ? 4 : 2;
            m_mis[k] = 1'b0;
            case (pc_src)
                2'd1:    tgt = m_pc[k] + imm;
                2'd2:    tgt = (rs1 + imm) & 32'hFFFF_FFFE;
                2'd3:    tgt = trap_vec - (trap_vec % ia);
                default: tgt = m_pc[k] + 32'd4;
            endcase
            if (!rst) begin
                m_mode[k] = 0;
                m_pc[k]   = RV;
                m_bad[k]  = 32'h0;
            end else if (m_mode[k] == 0) begin
                m_mode[k] = 1;
            end else if (m_mode[k] == 2) begin
                if (redirect && pc_src == 2'd3) begin
                    m_pc[k]   = tgt;
                    m_mode[k] = 1;
                end
            end else if (redirect && pc_src != 2'd0) begin
                if (pc_src != 2'd3 && (tgt % ia) != 0) begin
                    m_mode[k] = 2;
                    m_mis[k]  = 1'b1;
                    m_bad[k]  = tgt;
                end else begin
                    m_pc[k] = tgt;
                end
            end else if (fetch_ready) begin
                m_pc[k] = m_pc[k] + 32'd4;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk($sformatf("%s_pc4", tag),    if4.pc,          m_pc[0]);
        chk($sformatf("%s_val4", tag),   32'(if4.fetch_valid), 32'(m_mode[0] == 1));
        chk($sformatf("%s_mis4", tag),   32'(if4.misaligned),  32'(m_mis[0]));
        chk($sformatf("%s_bad4", tag),   if4.bad_addr,    m_bad[0]);
        chk($sformatf("%s_link4", tag),  if4.pc_link,     m_pc[0] + 32'd4);
        chk($sformatf("%s_pc2", tag),    if2.pc,          m_pc[1]);
        chk($sformatf("%s_val2", tag),   32'(if2.fetch_valid), 32'(m_mode[1] == 1));
        chk($sformatf("%s_mis2", tag),   32'(if2.misaligned),  32'(m_mis[1]));
        chk($sformatf("%s_bad2", tag),   if2.bad_addr,    m_bad[1]);
        chk($sformatf("%s_link2", tag),  if2.pc_link,     m_pc[1] + 32'd4);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic redir(input logic [1:0] s, input logic [31:0] i, input logic [31:0] r,
                         input logic [31:0] t, input string tag);
        pc_src   = s;
        redirect = 1'b1;
        imm      = i;
        rs1      = r;
        trap_vec = t;
        tick(tag);
        redirect = 1'b0;
        pc_src   = PC_SRC_SEQ;
    endtask

    initial begin
        rst         = 1'b0;
        redirect    = 1'b0;
        pc_src      = PC_SRC_SEQ;
        imm         = 32'h0;
        rs1         = 32'h0;
        trap_vec    = 32'h0;
        fetch_ready = 1'b1;
        model_reset();

        tick("in_reset");
        tick("in_reset");

        // release between edges: reset vector shown, no request yet
        rst = 1'b1;
        #1;
        check_all("released");
        chk("boot_valid", 32'(if4.fetch_valid), 32'h0);
        tick("first");
        chk("first_pc", if4.pc, 32'h100);
        chk("first_valid", 32'(if4.fetch_valid), 32'h1);
        tick("second");
        chk("second_pc", if4.pc, 32'h104);
        tick("third");
        chk("third_pc", if4.pc, 32'h108);

        // stall
        redir(PC_SRC_TRAP, 32'h0, 32'h0, 32'h200, "to200");
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick("stall");
            chk("stall_pc", if4.pc, 32'h200);
        end
        fetch_ready = 1'b1;
        tick("unstall");
        chk("unstall_pc", if4.pc, 32'h204);

        // redirects
        redir(PC_SRC_TRAP, 32'h0, 32'h0, 32'h300, "to300");
        chk("link300", if4.pc_link, 32'h304);
        redir(PC_SRC_BRANCH, 32'hFFFF_FFF8, 32'h0, 32'h0, "br_m8");
        chk("br_m8_pc4", if4.pc, 32'h2F8);
        chk("br_m8_pc2", if2.pc, 32'h2F8);
        redir(PC_SRC_JALR, 32'h2, 32'h1001, 32'h0, "jalr");
        chk("jalr_pc2", if2.pc, 32'h1002);
        chk("jalr_mis4", 32'(if4.misaligned), 32'h1);

        // misaligned halt and trap recovery
        redir(PC_SRC_TRAP, 32'h0, 32'h0, 32'h400, "to400");
        redir(PC_SRC_BRANCH, 32'h6, 32'h0, 32'h0, "br6");
        chk("br6_mis4", 32'(if4.misaligned), 32'h1);
        chk("br6_bad4", if4.bad_addr, 32'h406);
        chk("br6_pc4", if4.pc, 32'h400);
        chk("br6_val4", 32'(if4.fetch_valid), 32'h0);
        chk("br6_pc2", if2.pc, 32'h406);
        tick("halt_seq");
        chk("halt_pc4", if4.pc, 32'h400);
        chk("halt_mis4", 32'(if4.misaligned), 32'h0);
        redir(PC_SRC_TRAP, 32'h0, 32'h0, 32'h803, "trap803");
        chk("trap_pc4", if4.pc, 32'h800);
        chk("trap_val4", 32'(if4.fetch_valid), 32'h1);

        // half-word alignment
        redir(PC_SRC_TRAP, 32'h0, 32'h0, 32'h400, "to400b");
        redir(PC_SRC_BRANCH, 32'h2, 32'h0, 32'h0, "br2");
        chk("br2_pc2", if2.pc, 32'h402);
        redir(PC_SRC_JALR, 32'h2, 32'h401, 32'h0, "jalr403");
        chk("jalr403_pc2", if2.pc, 32'h402);
        chk("jalr403_mis2", 32'(if2.misaligned), 32'h0);

        // wrap
        redir(PC_SRC_TRAP, 32'h0, 32'h0, 32'hFFFF_FFFC, "towrap");
        tick("wrap");
        chk("wrap_pc4", if4.pc, 32'h0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            pc_src      = 2'($urandom_range(0, 3));
            redirect    = ($urandom_range(0, 3) == 0);
            imm         = 32'($urandom_range(0, 32)) - 32'd16;
            rs1         = $urandom & 32'h0000_FFFF;
            trap_vec    = $urandom;
            fetch_ready = ($urandom_range(0, 3) != 0);
            tick("rnd");
        end

        // asynchronous reset mid-run
        redirect    = 1'b0;
        fetch_ready = 1'b1;
        redir(PC_SRC_TRAP, 32'h0, 32'h0, 32'h40, "to40");
        tick("pre_rst");
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pc4", if4.pc, RV);
        chk("arst_val4", 32'(if4.fetch_valid), 32'h0);
        chk("arst_pc2", if2.pc, RV);
        model_reset();
        check_all("arst");
        tick("arst_hold");
        rst = 1'b1;
        tick("reboot");
        chk("reboot_pc4", if4.pc, RV);
        chk("reboot_val4", 32'(if4.fetch_valid), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
